// File: rtl/reg_file_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports with busy
// status, one write port, one reserve port, flush and the busy count.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              we;
  logic [ADDR_W-1:0] wd_addr;
  logic [DATA_W-1:0] w_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              flush;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rs_addr, rt_addr, we, wd_addr, w_data, rsv_en, rsv_addr, flush,
    input  rs_data, rt_data, rs_busy, rt_busy, busy_cnt
  );

  modport slave (
    input  rs_addr, rt_addr, we, wd_addr, w_data, rsv_en, rsv_addr, flush,
    output rs_data, rt_data, rs_busy, rt_busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard. Reads are combinational
// with write-data and busy bypass; a reserve marks a register as awaiting a
// producer, and the producer's write releases it. busy_cnt is the registered
// population count of the busy bits.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_nxt;
  logic              wr_ok;
  logic              rsv_ok;

  // Register 0 is hardwired when ZERO_REG is set.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify write and reserve; flush overrides any reserve in the same cycle.
  always_comb begin
    wr_ok  = bus.we && !is_zero(bus.wd_addr);
    rsv_ok = bus.rsv_en && !is_zero(bus.rsv_addr) && !bus.flush;
  end

  // Next busy vector (release first so a same-cycle reserve wins) and its popcount.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (bus.we) busy_nxt[bus.wd_addr] = 1'b0;
      if (rsv_ok) busy_nxt[bus.rsv_addr] = 1'b1;
    end
    busy_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_nxt = busy_cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // Scoreboard state and busy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= busy_cnt_nxt;
    end
  end

  // Data storage; cleared by reset so reads return 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.wd_addr] <= bus.w_data;
    end
  end

  // Read ports: a qualified write to the same address is forwarded, and a
  // write to the addressed register hides its busy bit in the same cycle.
  assign bus.rs_data = is_zero(bus.rs_addr) ? '0 :
                       (wr_ok && bus.wd_addr == bus.rs_addr) ? bus.w_data :
                       mem[bus.rs_addr];
  assign bus.rt_data = is_zero(bus.rt_addr) ? '0 :
                       (wr_ok && bus.wd_addr == bus.rt_addr) ? bus.w_data :
                       mem[bus.rt_addr];
  assign bus.rs_busy = !is_zero(bus.rs_addr) && busy[bus.rs_addr] &&
                       !(bus.we && bus.wd_addr == bus.rs_addr);
  assign bus.rt_busy = !is_zero(bus.rt_addr) && busy[bus.rt_addr] &&
                       !(bus.we && bus.wd_addr == bus.rt_addr);
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios followed by random traffic, all
// checked against an array-based model of the register file and scoreboard.
`timescale 1ns/1ps
module tb_reg_file_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents and busy flags as plain arrays.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_busy [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += ref_busy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (a == 0) return '0;
    if (bus.we && int'(bus.wd_addr) == a) return bus.w_data;
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (bus.we && int'(bus.wd_addr) == a) return 1'b0;
    return ref_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (bus.we && bus.wd_addr != 0) ref_mem[bus.wd_addr] = bus.w_data;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ref_busy[i] = 1'b0;
    end else begin
      if (bus.we) ref_busy[bus.wd_addr] = 1'b0;
      if (bus.rsv_en && bus.rsv_addr != 0) ref_busy[bus.rsv_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wd_addr = '0; bus.w_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.flush = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the
  // falling edge, the model steps on the rising edge, then busy_cnt is compared.
  task automatic cycle();
    @(negedge clk);
    chk("rs_data", bus.rs_data, exp_data(int'(bus.rs_addr)));
    chk("rt_data", bus.rt_data, exp_data(int'(bus.rt_addr)));
    chk("rs_busy", bus.rs_busy, exp_busy(int'(bus.rs_addr)));
    chk("rt_busy", bus.rt_busy, exp_busy(int'(bus.rt_addr)));
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_cnt", bus.busy_cnt, ref_count());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    bus.rs_addr = '0; bus.rt_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("busy_cnt_in_reset", bus.busy_cnt, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Read every address after reset.
    for (int a = 0; a < DEPTH; a++) begin
      bus.rs_addr = a[ADDR_W-1:0];
      bus.rt_addr = 5'(DEPTH - 1 - a);
      cycle();
    end

    // Write bypass and subsequent read of reg 5.
    bus.we = 1'b1; bus.wd_addr = 5'd5; bus.w_data = 32'hDEADBEEF; bus.rs_addr = 5'd5;
    #1 chk("bypass_rs5", bus.rs_data, 32'hDEADBEEF);
    cycle();
    idle(); bus.rt_addr = 5'd5;
    #1 chk("read_rt5", bus.rt_data, 32'hDEADBEEF);
    cycle();

    // Register 0 ignores writes and reserves.
    bus.we = 1'b1; bus.wd_addr = 5'd0; bus.w_data = 32'h12345678;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; bus.rs_addr = 5'd0;
    cycle();
    idle(); bus.rs_addr = 5'd0;
    #1;
    chk("zero_data", bus.rs_data, 0);
    chk("zero_busy", bus.rs_busy, 0);
    chk("zero_cnt", bus.busy_cnt, 0);

    // Reserve 3,4,7; release 4; reserve and write 3 together.
    bus.rsv_en = 1'b1;
    bus.rsv_addr = 5'd3; cycle(); chk("cnt_after_r3", bus.busy_cnt, 1);
    bus.rsv_addr = 5'd4; cycle(); chk("cnt_after_r4", bus.busy_cnt, 2);
    bus.rsv_addr = 5'd7; cycle(); chk("cnt_after_r7", bus.busy_cnt, 3);
    idle(); bus.we = 1'b1; bus.wd_addr = 5'd4; bus.w_data = 32'h44; bus.rs_addr = 5'd4;
    #1 chk("busy4_hidden", bus.rs_busy, 0);
    cycle(); chk("cnt_after_w4", bus.busy_cnt, 2);
    bus.wd_addr = 5'd3; bus.w_data = 32'h33; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    cycle(); chk("cnt_rsv_wr3", bus.busy_cnt, 2);
    idle(); bus.rs_addr = 5'd3;
    #1;
    chk("busy3_kept", bus.rs_busy, 1);
    chk("data3_written", bus.rs_data, 32'h33);

    // Reserve all of 1..31, then flush while reserving 9.
    for (int a = 1; a < DEPTH; a++) begin
      bus.rsv_en = 1'b1; bus.rsv_addr = a[ADDR_W-1:0];
      cycle();
    end
    chk("cnt_full", bus.busy_cnt, 31);
    bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9; bus.rs_addr = 5'd9;
    cycle();
    chk("cnt_flush", bus.busy_cnt, 0);
    idle(); bus.rs_addr = 5'd9;
    #1 chk("busy9_flushed", bus.rs_busy, 0);

    // Asynchronous reset in mid-cycle with reg 10 written and busy.
    bus.we = 1'b1; bus.wd_addr = 5'd10; bus.w_data = 32'hA5A5A5A5;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd10;
    cycle();
    idle(); bus.rs_addr = 5'd10; bus.rt_addr = 5'd10;
    #1;
    chk("r10_before_rst", bus.rs_data, 32'hA5A5A5A5);
    chk("b10_before_rst", bus.rs_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("r10_async_rst", bus.rs_data, 0);
    chk("b10_async_rst", bus.rs_busy, 0);
    chk("cnt_async_rst", bus.busy_cnt, 0);
    model_reset();

    // Activity during reset: bypass visible, nothing stored.
    bus.we = 1'b1; bus.wd_addr = 5'd12; bus.w_data = 32'h77;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12; bus.rs_addr = 5'd12;
    #1;
    chk("bypass_in_rst", bus.rs_data, 32'h77);
    chk("busy_in_rst", bus.rs_busy, 0);
    @(posedge clk); #1;
    idle();
    #1;
    chk("no_write_in_rst", bus.rs_data, 0);
    chk("no_rsv_in_rst", bus.busy_cnt, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      bus.we       = ($urandom_range(0, 1) == 1);
      bus.wd_addr  = 5'($urandom_range(0, DEPTH - 1));
      bus.w_data   = $urandom;
      bus.rsv_en   = ($urandom_range(0, 1) == 1);
      bus.rsv_addr = ($urandom_range(0, 3) == 0) ? bus.wd_addr : 5'($urandom_range(0, DEPTH - 1));
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.rs_addr  = ($urandom_range(0, 2) == 0) ? bus.wd_addr : 5'($urandom_range(0, DEPTH - 1));
      bus.rt_addr  = ($urandom_range(0, 2) == 0) ? bus.rsv_addr : 5'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
